// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial bit-pattern transmitter for the serial sequence detectors.
// Latches a PAT_W-bit pattern on start and shifts it out MSB first, repeating it
// max(reps,1) times with GAP idle cycles between repetitions. All outputs are registered.
// Build option: define SEQ_TX_PARITY_EN to append an even-parity bit after every pattern.
module seq_pattern_tx #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1101,
    parameter int unsigned      GAP     = 2,
    parameter int unsigned      CNT_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             use_def_i,
    input  logic [CNT_W-1:0] reps_i,
    input  logic             abort_i,
    output logic             out_bit_o,
    output logic             bit_valid_o,
    output logic             frame_start_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned        BitCntW = $clog2(PAT_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(PAT_W - 1);
    localparam logic [3:0]         GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StSend, StPar, StGap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
`endif

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shreg_q, shreg_d;  // bits still to send after the one on out_bit
    logic [PAT_W-1:0]   pat_q, pat_d;      // latched pattern, reloaded for each repetition
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;  // index of the bit currently on out_bit
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               out_bit_q, out_bit_d;
    logic               bit_valid_q, bit_valid_d;
    logic               frame_start_q, frame_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               frame_end;
    logic               launch;
    logic [PAT_W-1:0]   launch_pat;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        pat_d         = pat_q;
        rep_d         = rep_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        out_bit_d     = 1'b0;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        frame_end     = 1'b0;
        launch        = 1'b0;
        launch_pat    = pat_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    launch_pat = use_def_i ? DEF_PAT : pat_i;
                    pat_d      = launch_pat;
                    rep_d      = (reps_i == '0) ? CNT_W'(1) : reps_i;
                    launch     = 1'b1;
                end
            end
            StSend: begin
                if (bit_cnt_q != LastBit) begin
                    out_bit_d   = shreg_q[PAT_W-1];
                    shreg_d     = shreg_q << 1;
                    bit_cnt_d   = bit_cnt_q + BitCntW'(1);
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d     = StPar;
                    out_bit_d   = ^pat_q;
                    bit_valid_d = 1'b1;
                    busy_d      = 1'b1;
`else
                    frame_end   = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            StPar: frame_end = 1'b1;
`endif
            StGap: begin
                busy_d = 1'b1;
                if (gap_cnt_q == 4'd0) begin
                    launch = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Last bit of a repetition is on the line: finish, pause, or restart the pattern.
        if (frame_end) begin
            rep_d = rep_q - CNT_W'(1);
            if (rep_q <= CNT_W'(1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else if (GAP == 0) begin
                launch = 1'b1;
            end else begin
                state_d   = StGap;
                gap_cnt_d = GapLast;
                busy_d    = 1'b1;
            end
        end

        // Put bit 0 of a repetition on the line.
        if (launch) begin
            state_d       = StSend;
            out_bit_d     = launch_pat[PAT_W-1];
            shreg_d       = launch_pat << 1;
            bit_cnt_d     = '0;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
        end

        // Abort overrides everything while busy; no done pulse.
        if (abort_i && (state_q != StIdle)) begin
            state_d       = StIdle;
            out_bit_d     = 1'b0;
            bit_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            pat_q         <= '0;
            rep_q         <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            out_bit_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            pat_q         <= pat_d;
            rep_q         <= rep_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            out_bit_q     <= out_bit_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign out_bit_o     = out_bit_q;
    assign bit_valid_o   = bit_valid_q;
    assign frame_start_o = frame_start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter that drives a single-bit stream (`out_bit`) for the team's serial sequence detectors. On a `start` pulse it latches a PAT_W-bit pattern (programmed or built-in default 1101) and shifts it out MSB first, one bit per clock. It repeats the pattern a programmable number of times, with a configurable idle gap between repetitions. It acts as the stimulus and source end of the serial detector interface, in both benches and in on-chip self-test.

## Interface
- PAT_W, 4: pattern length in bits (2..16)
- DEF_PAT, 4'b1101: built-in pattern, used when `use_def`=1
- GAP, 2: idle cycles between repetitions (0..15)
- CNT_W, 4: width of repetition count

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a transmission; sampled only in IDLE
- pat  in  PAT_W  pattern, latched when start is accepted
- use_def  in  1  1 = transmit DEF_PAT and ignore `pat`
- reps  in  CNT_W  number of repetitions, latched at start; 0 is treated as 1
- abort  in  1  terminate the current transmission
- out_bit  out  1  serial data; 0 whenever bit_valid=0
- bit_valid  out  1  out_bit carries a pattern/parity bit this cycle
- frame_start  out  1  high on the first bit of each repetition
- busy  out  1  transmitter not in IDLE
- done  out  1  one-cycle pulse after the final bit of the final repetition

## Operation
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE, shift register and counters reset to 0.
- States: IDLE, SEND, PAR (only when the parity macro is defined), GAP.
- IDLE -> SEND on start=1 and abort=0.
  - Latch the pattern (DEF_PAT or `pat`) into the shift register.
  - Latch the repetition count (max(reps,1)).
  - Clear the bit counter.
- SEND:
  - Drive the MSB of the shift register; shift left each cycle.
  - Bit counter runs 0..PAT_W-1.
  - frame_start=1 when the counter is 0.
- After the last bit:
  - Go to PAR if enabled.
  - Otherwise, if repetitions remain, go to GAP (or directly to SEND if GAP=0), reloading the latched pattern.
  - Otherwise go to IDLE and pulse done.
- GAP: out_bit=0, bit_valid=0 for exactly GAP cycles, then SEND.
- Repetition counter decrements once per completed pattern. No wrap: the transmission ends when it reaches 0.
- start while busy is ignored and has no queuing.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE.
  - bit_valid, busy and frame_start go to 0.
  - done is not pulsed.
- abort and start in the same IDLE cycle: abort wins and start is dropped.
- rst=1 mid-transmission behaves like abort, and also clears all registers.
- `pat`/`use_def`/`reps` changes while busy have no effect.

## Timing
- Let start be sampled at edge E0.
  - First bit is valid from E0 to E1, so latency is 1 cycle.
  - Bit k of a repetition is driven after edge E0+k.
- With reps=1 and no parity: done=1 and busy=0 in the cycle after E0+PAT_W. bit_valid=0 in that same cycle.
- Between repetitions: exactly GAP invalid cycles. With GAP=0 the bits are back-to-back, with no bubble.
- A new start is accepted in the same cycle that done=1, because the FSM is in IDLE.
- A new start is also accepted in the cycle after an abort takes effect.
- Throughput: one bit per clock while in SEND/PAR.

## Configuration
- `SEQ_TX_PARITY_EN`:
  - Defined: after each pattern, one extra bit is sent with bit_valid=1. Its value is the even parity (XOR) of the PAT_W pattern bits. This adds 1 cycle per repetition, and the done/gap timing shifts by 1 cycle.
  - Undefined: the PAR state and its logic are absent, and frames are exactly PAT_W bits.

## Test plan
- Reset: hold rst=1 for 2 cycles during an active SEND -> all outputs 0 the next cycle; start is accepted afterwards.
- use_def=1, reps=1, GAP=2, start at E0 -> out_bit 1,1,0,1 after E0..E3 with bit_valid=1 and frame_start only after E0 -> done=1 and busy=0 after E4.
- pat=4'b1010, use_def=0, reps=3, GAP=0 -> 12 contiguous valid bits 101010101010 -> frame_start on bits 0, 4, 8 -> a single done pulse.
- use_def=1, reps=2, GAP=2 -> 1101, 2 invalid cycles with out_bit=0, then 1101 -> done after the second frame.
- abort after the 2nd bit -> next cycle bit_valid=0, busy=0, done=0. Also: start while busy is ignored, and reps=0 sends exactly one frame.
- SEQ_TX_PARITY_EN defined, use_def=1, reps=1 -> 1,1,0,1,1, then done. Undefined -> 1,1,0,1, then done.
